mem_arbiter: RTL

- Responder for the core's two memory initiator ports: instruction fetch (read-only) and data load/store.
- Arbitrates them onto one shared memory initiator bus using the same access/ack protocol, and returns ack and read data to the granted port.
- Sits between Core and the system memory/bus fabric. Round-robin on contention so neither prefetch nor load/store starves.

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/rr_arbiter_2.sv | 25 ++
 rtl/mem_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the core memory-port arbiter: grant encoding,
// FSM state type and the fixed byte-lane pattern used for instruction fetch.
package mem_arbiter_pkg;

    localparam logic       GRANT_INSTR   = 1'b0;
    localparam logic       GRANT_DATA    = 1'b1;
    localparam logic [1:0] INSTR_BYTESEL = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin pick. On contention the requester that did not
// win last time is chosen; a lone requester always wins.
module rr_arbiter_2
    import mem_arbiter_pkg::*;
(
    input  logic req_instr,
    input  logic req_data,
    input  logic last_grant,
    output logic any_req,
    output logic grant
);

    // Combinational pick from the current request pair and the previous winner
    always_comb begin
        any_req = req_instr | req_data;
        if (req_instr && req_data) begin
            grant = ~last_grant;
        end else if (req_data) begin
            grant = GRANT_DATA;
        end else begin
            grant = GRANT_INSTR;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the core's instruction-fetch and data load/store initiator
// ports onto one shared memory bus, returning acks to the granted port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] instr_m_addr,
    input  logic                  instr_m_access,
    output logic                  instr_m_ack,
    output logic [DATA_WIDTH-1:0] instr_m_data_in,
    input  logic [ADDR_WIDTH-1:0] data_m_addr,
    input  logic [DATA_WIDTH-1:0] data_m_data_out,
    output logic [DATA_WIDTH-1:0] data_m_data_in,
    input  logic                  data_m_access,
    output logic                  data_m_ack,
    input  logic                  data_m_wr_en,
    input  logic [1:0]            data_m_bytesel,
    output logic [ADDR_WIDTH-1:0] q_m_addr,
    output logic [DATA_WIDTH-1:0] q_m_data_out,
    input  logic [DATA_WIDTH-1:0] q_m_data_in,
    output logic                  q_m_access,
    input  logic                  q_m_ack,
    output logic                  q_m_wr_en,
    output logic [1:0]            q_m_bytesel,
    output logic                  q_m_grant_data
);

    state_t state;
    state_t state_next;
    logic   last_grant;
    logic   any_req;
    logic   pick;
    logic   grant_edge;
    logic   done_edge;

    rr_arbiter_2 u_rr (
        .req_instr  (instr_m_access),
        .req_data   (data_m_access),
        .last_grant (last_grant),
        .any_req    (any_req),
        .grant      (pick)
    );

    assign grant_edge = (state == IDLE) && any_req;
    assign done_edge  = (state == GRANT) && q_m_ack;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: leave IDLE on any request, return on memory completion
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = GRANT;
            GRANT:   if (q_m_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shared-bus request fields captured at grant, plus round-robin history
    always_ff @(posedge clk) begin
        if (reset) begin
            q_m_addr       <= '0;
            q_m_data_out   <= '0;
            q_m_wr_en      <= 1'b0;
            q_m_bytesel    <= '0;
            q_m_grant_data <= GRANT_INSTR;
            last_grant     <= GRANT_INSTR;
        end else begin
            if (grant_edge) begin
                q_m_grant_data <= pick;
                if (pick == GRANT_DATA) begin
                    q_m_addr     <= data_m_addr;
                    q_m_data_out <= data_m_data_out;
                    q_m_wr_en    <= data_m_wr_en;
                    q_m_bytesel  <= data_m_bytesel;
                end else begin
                    q_m_addr     <= instr_m_addr;
                    q_m_data_out <= '0;
                    q_m_wr_en    <= 1'b0;
                    q_m_bytesel  <= INSTR_BYTESEL;
                end
            end
            if (done_edge) begin
                last_grant <= q_m_grant_data;
            end
        end
    end

    // Outputs: bus request follows GRANT; completion is passed through to the granted port only
    always_comb begin
        q_m_access      = (state == GRANT);
        instr_m_ack     = done_edge && (q_m_grant_data == GRANT_INSTR);
        data_m_ack      = done_edge && (q_m_grant_data == GRANT_DATA);
        instr_m_data_in = q_m_data_in;
        data_m_data_in  = q_m_data_in;
    end

endmodule
